pipeline_stage_decode: RTL and testbench

Second pipeline stage: consumes the fetch-stage result register and produces the decode result register consumed by execution. It holds the architectural register file, reads operands, and detects load-use hazards, driving `stallOnDecode` back to fetch. It also discards wrong-path instructions after a jump, using the fetch stage's `programCounterChangedTimes` toggle bit.

---
 rtl/pipeline_stage_decode.sv | 168 ++++++++++++++++
 tb/tb_pipeline_stage_decode.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_decode.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stage_decode
// Purpose  : Decode stage. Holds the register file, reads operands, detects
//            load-use hazards (stalling fetch) and discards wrong-path fetch
//            results after a jump using the fetch PC toggle bit.
// Option   : PIPELINE_DECODE_WRITE_BYPASS_EN - forward a same-cycle writeback
//            into the operand read instead of stalling for it.
// Revision : 1.0 - initial release
// ============================================================================

package pipeline_decode_pkg;
   typedef struct packed {
      logic [7:0] opcode;
      logic [4:0] destinationRegister;
      logic [4:0] sourceRegister1;
      logic [4:0] sourceRegister2;
      logic       readsSource1;
      logic       readsSource2;
      logic       memoryRead;
   } instruction_t;
endpackage

module pipeline_stage_decode
   import pipeline_decode_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int REG_COUNT   = 32,
   parameter int INSTR_WIDTH = $bits(instruction_t)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [DATA_WIDTH-1:0]  fetchProgramCounter,
   input  logic                   fetchChangedTimes,
   input  logic [INSTR_WIDTH-1:0] fetchInstruction,
   input  logic                   jumpEnabled,
   input  logic                   writebackEnabled,
   input  logic [4:0]             writebackRegister,
   input  logic [DATA_WIDTH-1:0]  writebackValue,
   output logic                   stallOnDecode,
   output logic                   decodeValid,
   output logic [DATA_WIDTH-1:0]  decodeProgramCounter,
   output logic [INSTR_WIDTH-1:0] decodeInstruction,
   output logic [DATA_WIDTH-1:0]  decodeOperand1,
   output logic [DATA_WIDTH-1:0]  decodeOperand2
);

   localparam logic [4:0] c_ZERO_REG = 5'd0;

   logic [DATA_WIDTH-1:0] r_regFile [REG_COUNT];
   logic                  r_primed;
   logic                  r_expectedChangedTimes;
   logic                  r_decodeValid;
   logic [DATA_WIDTH-1:0] r_decodeProgramCounter;
   instruction_t          r_decodeInstruction;
   logic [DATA_WIDTH-1:0] r_decodeOperand1;
   logic [DATA_WIDTH-1:0] r_decodeOperand2;

   instruction_t          w_fetch;
   logic                  w_live;
   logic                  w_loadUse;
   logic                  w_writeMatch1;
   logic                  w_writeMatch2;
   logic                  w_hazard;
   logic [DATA_WIDTH-1:0] w_operand1;
   logic [DATA_WIDTH-1:0] w_operand2;

   assign w_fetch = instruction_t'(fetchInstruction);

   // A fetch result counts only once primed and only on the current PC path.
   assign w_live = r_primed && (fetchChangedTimes == r_expectedChangedTimes);

   // Load in the decode register whose destination feeds the live input.
   always_comb begin
      w_loadUse = 1'b0;
      if (w_live && r_decodeValid && r_decodeInstruction.memoryRead &&
          (r_decodeInstruction.destinationRegister != c_ZERO_REG)) begin
         if (w_fetch.readsSource1 &&
             (w_fetch.sourceRegister1 == r_decodeInstruction.destinationRegister))
            w_loadUse = 1'b1;
         if (w_fetch.readsSource2 &&
             (w_fetch.sourceRegister2 == r_decodeInstruction.destinationRegister))
            w_loadUse = 1'b1;
      end
   end

   // Operand reads that collide with this cycle's register-file write.
   assign w_writeMatch1 = writebackEnabled && (writebackRegister != c_ZERO_REG) &&
                          w_fetch.readsSource1 &&
                          (w_fetch.sourceRegister1 == writebackRegister);
   assign w_writeMatch2 = writebackEnabled && (writebackRegister != c_ZERO_REG) &&
                          w_fetch.readsSource2 &&
                          (w_fetch.sourceRegister2 == writebackRegister);

`ifdef PIPELINE_DECODE_WRITE_BYPASS_EN
   assign w_hazard = w_loadUse;
`else
   // Without forwarding, wait one cycle so the write lands in the file first.
   assign w_hazard = w_loadUse || (w_live && (w_writeMatch1 || w_writeMatch2));
`endif

   // Hold fetch on a hazard, but never while a jump redirects or in reset.
   assign stallOnDecode = reset && !jumpEnabled && w_hazard;

   // Operand read; unread sources and register 0 yield zero.
   always_comb begin
      w_operand1 = '0;
      w_operand2 = '0;
      if (w_fetch.readsSource1 && (w_fetch.sourceRegister1 != c_ZERO_REG))
         w_operand1 = r_regFile[w_fetch.sourceRegister1];
      if (w_fetch.readsSource2 && (w_fetch.sourceRegister2 != c_ZERO_REG))
         w_operand2 = r_regFile[w_fetch.sourceRegister2];
`ifdef PIPELINE_DECODE_WRITE_BYPASS_EN
      if (w_writeMatch1)
         w_operand1 = writebackValue;
      if (w_writeMatch2)
         w_operand2 = writebackValue;
`endif
   end

   // Register file: writes every requested cycle, register 0 stays zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REG_COUNT; i++)
            r_regFile[i] <= '0;
      end else if (writebackEnabled && (writebackRegister != c_ZERO_REG)) begin
         r_regFile[writebackRegister] <= writebackValue;
      end
   end

   // Decode result register and path-tracking state, jump first, then hazard.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_primed               <= 1'b0;
         r_expectedChangedTimes <= 1'b0;
         r_decodeValid          <= 1'b0;
         r_decodeProgramCounter <= '0;
         r_decodeInstruction    <= '0;
         r_decodeOperand1       <= '0;
         r_decodeOperand2       <= '0;
      end else begin
         r_primed <= 1'b1;
         if (!jumpEnabled && !w_hazard && w_live) begin
            r_decodeValid          <= 1'b1;
            r_decodeProgramCounter <= fetchProgramCounter;
            r_decodeInstruction    <= w_fetch;
            r_decodeOperand1       <= w_operand1;
            r_decodeOperand2       <= w_operand2;
         end else begin
            r_decodeValid          <= 1'b0;
            r_decodeProgramCounter <= '0;
            r_decodeInstruction    <= '0;
            r_decodeOperand1       <= '0;
            r_decodeOperand2       <= '0;
         end
         if (jumpEnabled)
            r_expectedChangedTimes <= ~r_expectedChangedTimes;
      end
   end

   assign decodeValid          = r_decodeValid;
   assign decodeProgramCounter = r_decodeProgramCounter;
   assign decodeInstruction    = r_decodeInstruction;
   assign decodeOperand1       = r_decodeOperand1;
   assign decodeOperand2       = r_decodeOperand2;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stage_decode
// Purpose  : Self-checking bench for pipeline_stage_decode: directed scenarios
//            with literal expectations, then randomized traffic compared
//            every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_decode;
   import pipeline_decode_pkg::*;

   localparam int DW = 32;
   localparam int IW = $bits(instruction_t);

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] fetchProgramCounter = '0;
   logic          fetchChangedTimes = 1'b0;
   logic [IW-1:0] fetchInstruction = '0;
   logic          jumpEnabled = 1'b0;
   logic          writebackEnabled = 1'b0;
   logic [4:0]    writebackRegister = '0;
   logic [DW-1:0] writebackValue = '0;
   logic          stallOnDecode;
   logic          decodeValid;
   logic [DW-1:0] decodeProgramCounter;
   logic [IW-1:0] decodeInstruction;
   logic [DW-1:0] decodeOperand1;
   logic [DW-1:0] decodeOperand2;

   int testsRun = 0;
   int testsFailed = 0;
   bit chkEn = 1'b0;

   pipeline_stage_decode dut (
      .clock                (clock),
      .reset                (reset),
      .fetchProgramCounter  (fetchProgramCounter),
      .fetchChangedTimes    (fetchChangedTimes),
      .fetchInstruction     (fetchInstruction),
      .jumpEnabled          (jumpEnabled),
      .writebackEnabled     (writebackEnabled),
      .writebackRegister    (writebackRegister),
      .writebackValue       (writebackValue),
      .stallOnDecode        (stallOnDecode),
      .decodeValid          (decodeValid),
      .decodeProgramCounter (decodeProgramCounter),
      .decodeInstruction    (decodeInstruction),
      .decodeOperand1       (decodeOperand1),
      .decodeOperand2       (decodeOperand2)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_rf [32];
   logic          m_primed, m_exp, m_valid;
   logic [DW-1:0] m_pc, m_op1, m_op2;
   instruction_t  m_instr;

   function automatic bit modelLive();
      return m_primed && (fetchChangedTimes == m_exp);
   endfunction

   // Stall = live input reads a register that is not ready yet.
   function automatic bit modelStall();
      instruction_t fi = instruction_t'(fetchInstruction);
      logic [4:0] srcs [2];
      bit rd [2];
      bit st = 1'b0;
      srcs[0] = fi.sourceRegister1; rd[0] = fi.readsSource1;
      srcs[1] = fi.sourceRegister2; rd[1] = fi.readsSource2;
      if (!reset || jumpEnabled || !modelLive()) return 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (rd[k] && srcs[k] != 0) begin
            if (m_valid && m_instr.memoryRead && m_instr.destinationRegister == srcs[k])
               st = 1'b1;
`ifndef PIPELINE_DECODE_WRITE_BYPASS_EN
            if (writebackEnabled && writebackRegister == srcs[k])
               st = 1'b1;
`endif
         end
      end
      return st;
   endfunction

   function automatic logic [DW-1:0] modelOperand(bit rd, logic [4:0] s);
      if (!rd || s == 0) return '0;
`ifdef PIPELINE_DECODE_WRITE_BYPASS_EN
      if (writebackEnabled && writebackRegister == s) return writebackValue;
`endif
      return m_rf[s];
   endfunction

   // Model update: the spec's per-edge priority rules.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) m_rf[i] <= '0;
         m_primed <= 1'b0; m_exp <= 1'b0; m_valid <= 1'b0;
         m_pc <= '0; m_op1 <= '0; m_op2 <= '0; m_instr <= '0;
      end else begin
         m_primed <= 1'b1;
         if (writebackEnabled && writebackRegister != 0)
            m_rf[writebackRegister] <= writebackValue;
         if (jumpEnabled) m_exp <= ~m_exp;
         if (!jumpEnabled && !modelStall() && modelLive()) begin
            m_valid <= 1'b1;
            m_pc    <= fetchProgramCounter;
            m_instr <= instruction_t'(fetchInstruction);
            m_op1   <= modelOperand(fetchInstruction[2], fetchInstruction[12:8]);
            m_op2   <= modelOperand(fetchInstruction[1], fetchInstruction[7:3]);
         end else begin
            m_valid <= 1'b0; m_pc <= '0; m_instr <= '0; m_op1 <= '0; m_op2 <= '0;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, mid-cycle.
   always @(negedge clock) begin
      if (chkEn) begin
         check("m.stall", 64'(stallOnDecode), 64'(modelStall()));
         check("m.valid", 64'(decodeValid), 64'(m_valid));
         check("m.pc", 64'(decodeProgramCounter), 64'(m_pc));
         check("m.instr", 64'(decodeInstruction), 64'(m_instr));
         check("m.op1", 64'(decodeOperand1), 64'(m_op1));
         check("m.op2", 64'(decodeOperand2), 64'(m_op2));
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic instruction_t mk(logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                       bit r1, bit r2, bit mr);
      instruction_t t;
      t.opcode = 8'h5A;
      t.destinationRegister = d;
      t.sourceRegister1 = s1;
      t.sourceRegister2 = s2;
      t.readsSource1 = r1;
      t.readsSource2 = r2;
      t.memoryRead = mr;
      return t;
   endfunction

   task automatic present(input logic [DW-1:0] pc, input bit tog, input instruction_t ins,
                          input bit jmp, input bit wbe, input logic [4:0] wbr,
                          input logic [DW-1:0] wbv);
      fetchProgramCounter = pc;
      fetchChangedTimes   = tog;
      fetchInstruction    = ins;
      jumpEnabled         = jmp;
      writebackEnabled    = wbe;
      writebackRegister   = wbr;
      writebackValue      = wbv;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      instruction_t nop;
      instruction_t ri;
      logic [DW-1:0] fPc;
      bit fTog, hold, jmp;
      int flipDelay;
      nop = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clock);
      #1;
      check("rst.valid", 64'(decodeValid), 64'd0);
      check("rst.stall", 64'(stallOnDecode), 64'd0);
      check("rst.op1", 64'(decodeOperand1), 64'd0);
      reset = 1'b1;
      chkEn = 1'b1;

      // First result after release is ignored; r5 written meanwhile.
      present(32'hDEAD, 1'b0, nop, 1'b0, 1'b1, 5'd5, 32'h1234);
      tick();
      check("first.ignored", 64'(decodeValid), 64'd0);
      present(32'h4, 1'b0, nop, 1'b0, 1'b1, 5'd0, 32'hFFFF);
      tick();
      check("second.valid", 64'(decodeValid), 64'd1);
      check("second.pc", 64'(decodeProgramCounter), 64'h4);

      // Read r5 and r0.
      present(32'h8, 1'b0, mk(5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 5'd0, 32'h0);
      #3 check("rd.stall", 64'(stallOnDecode), 64'd0);
      tick();
      check("rd.r5", 64'(decodeOperand1), 64'h1234);
      check("rd.r0", 64'(decodeOperand2), 64'h0);

      // Load-use on r3.
      present(32'hC, 1'b0, mk(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      present(32'h10, 1'b0, mk(5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 5'd0, 32'h0);
      #3 check("lu.stall", 64'(stallOnDecode), 64'd1);
      tick();
      check("lu.bubble", 64'(decodeValid), 64'd0);
      #3 check("lu.release", 64'(stallOnDecode), 64'd0);
      tick();
      check("lu.issue", 64'(decodeValid), 64'd1);
      check("lu.pc", 64'(decodeProgramCounter), 64'h10);

      // Jump together with a hazard.
      present(32'h14, 1'b0, mk(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      present(32'h18, 1'b0, mk(5'd4, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 5'd0, 32'h0);
      #3 check("jmp.stall", 64'(stallOnDecode), 64'd0);
      tick();
      check("jmp.bubble", 64'(decodeValid), 64'd0);
      present(32'h1C, 1'b0, nop, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      check("stale1", 64'(decodeValid), 64'd0);
      present(32'h20, 1'b0, nop, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      check("stale2", 64'(decodeValid), 64'd0);
      present(32'h100, 1'b1, nop, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      check("newpath.valid", 64'(decodeValid), 64'd1);
      check("newpath.pc", 64'(decodeProgramCounter), 64'h100);

      // Same-cycle writeback of r7.
      present(32'h104, 1'b1, mk(5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, 5'd7, 32'hABCD);
`ifdef PIPELINE_DECODE_WRITE_BYPASS_EN
      #3 check("wb.stall", 64'(stallOnDecode), 64'd0);
      tick();
      check("wb.valid", 64'(decodeValid), 64'd1);
      check("wb.op1", 64'(decodeOperand1), 64'hABCD);
`else
      #3 check("wb.stall", 64'(stallOnDecode), 64'd1);
      tick();
      check("wb.bubble", 64'(decodeValid), 64'd0);
      writebackEnabled = 1'b0;
      #3 check("wb.release", 64'(stallOnDecode), 64'd0);
      tick();
      check("wb.valid", 64'(decodeValid), 64'd1);
      check("wb.op1", 64'(decodeOperand1), 64'hABCD);
`endif

      // Reset in the middle of a stall.
      present(32'h108, 1'b1, mk(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      present(32'h10C, 1'b1, mk(5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 5'd0, 32'h0);
      #3 check("mrst.stallBefore", 64'(stallOnDecode), 64'd1);
      reset = 1'b0;
      #1;
      check("mrst.stall", 64'(stallOnDecode), 64'd0);
      check("mrst.valid", 64'(decodeValid), 64'd0);
      check("mrst.pc", 64'(decodeProgramCounter), 64'd0);
      check("mrst.instr", 64'(decodeInstruction), 64'd0);
      repeat (2) tick();
      reset = 1'b1;

      // Randomized traffic with a fetch that honours stalls and jumps.
      fPc = 32'h1000;
      fTog = 1'b0;
      hold = 1'b0;
      flipDelay = 0;
      ri = nop;
      for (int c = 0; c < 600; c++) begin
         if (!hold) begin
            fPc += 4;
            ri = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 2) == 0);
            ri.opcode = 8'($urandom);
         end
         jmp = (flipDelay == 0) && ($urandom_range(0, 9) == 0);
         present(fPc, fTog, ri, jmp, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom);
         hold = modelStall();
         if (jmp) flipDelay = $urandom_range(1, 3);
         tick();
         if (flipDelay > 0) begin
            flipDelay--;
            if (flipDelay == 0) fTog = ~fTog;
         end
      end

      chkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
`default_nettype wire
